// File: rtl/sd_arb_pkg.sv
// rtl/sd_arb_pkg.sv - shared types and constants for the SD path arbiter
// Contents: state_t (arbiter FSM states), SEL_PHYS / SEL_VIRT (vsd_sel encodings).
package sd_arb_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PEND    = 2'd1,
        SWITCH  = 2'd2,
        RSTHOLD = 2'd3
    } state_t;

    localparam logic SEL_PHYS = 1'b0;
    localparam logic SEL_VIRT = 1'b1;

endpackage

// File: rtl/sd_bus_idle_mon.sv
// rtl/sd_bus_idle_mon.sv - detects a quiet core SPI bus (deselected, no clock activity)
// Ports:
//   clk_sys  in   system clock
//   reset    in   asynchronous active-high reset
//   sck      in   core SPI clock
//   ss       in   core SPI select, active low
//   bus_idle out  high once IDLE_CYCLES consecutive quiet cycles have been seen
module sd_bus_idle_mon #(
    parameter int IDLE_CYCLES = 64
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic sck,
    input  logic ss,
    output logic bus_idle
);

    localparam int CW = $clog2(IDLE_CYCLES + 1);

    logic [CW-1:0] idle_cnt;
    logic          sck_q;

    // Any sck edge is caught by comparing against last cycle's sample, so a
    // stalled clock level (high or low) counts as quiet.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
            sck_q    <= 1'b0;
        end else begin
            sck_q <= sck;
            if (!ss || (sck != sck_q)) begin
                idle_cnt <= '0;
            end else if (idle_cnt != CW'(IDLE_CYCLES)) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    assign bus_idle = (idle_cnt == CW'(IDLE_CYCLES));

endmodule

// File: rtl/sd_path_arbiter.sv
// rtl/sd_path_arbiter.sv - shares the core SPI SD port between the physical slot and the virtual SD
// Ports:
//   clk_sys, reset                      clock, asynchronous active-high reset
//   img_mounted, img_size               mount strobe and image size (nonzero selects virtual)
//   rst_after_mnt                       request a core reset after each switch
//   core_sck/core_mosi/core_ss          SPI from the core; core_miso back to the core
//   vsd_ss, vsd_miso                    virtual SD select / data in
//   phys_cs, phys_sck, phys_mosi        physical slot SPI out; phys_miso in
//   vsd_sel                             current selection, 1 = virtual
//   core_reset                          stretched reset request after a switch
//   sd_act                              activity indicator
//   busy                                high while a switch is pending or in progress
module sd_path_arbiter
    import sd_arb_pkg::*;
#(
    parameter int IDLE_CYCLES  = 64,
    parameter int PEND_TIMEOUT = 1048576,
    parameter int RST_CYCLES   = 1024,
    parameter int ACT_TIMEOUT  = 1000000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        img_mounted,
    input  logic [63:0] img_size,
    input  logic        rst_after_mnt,
    input  logic        core_sck,
    input  logic        core_mosi,
    input  logic        core_ss,
    output logic        core_miso,
    output logic        vsd_ss,
    input  logic        vsd_miso,
    output logic        phys_cs,
    output logic        phys_sck,
    output logic        phys_mosi,
    input  logic        phys_miso,
    output logic        vsd_sel,
    output logic        core_reset,
    output logic        sd_act,
    output logic        busy
);

    localparam int PW = $clog2(PEND_TIMEOUT + 1);
    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int AW = $clog2(ACT_TIMEOUT + 1);

    state_t        state;
    logic          target;
    logic          forced;
    logic          mnt_pend;
    logic [PW-1:0] pend_cnt;
    logic [RW-1:0] rst_cnt;
    logic [AW-1:0] act_cnt;
    logic          mosi_q;
    logic          miso_q;
    logic          bus_idle;
    logic          gate;
    logic          new_tgt;
    logic          run_tgt;

    sd_bus_idle_mon #(
        .IDLE_CYCLES(IDLE_CYCLES)
    ) u_idle_mon (
        .clk_sys (clk_sys),
        .reset   (reset),
        .sck     (core_sck),
        .ss      (core_ss),
        .bus_idle(bus_idle)
    );

    assign new_tgt = |img_size;
    // A mount that arrived while switching is replayed from RUN using the
    // latched target; a fresh strobe in RUN takes precedence over it.
    assign run_tgt = img_mounted ? new_tgt : target;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            target     <= SEL_PHYS;
            forced     <= 1'b0;
            mnt_pend   <= 1'b0;
            pend_cnt   <= '0;
            rst_cnt    <= '0;
            vsd_sel    <= SEL_PHYS;
            core_reset <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (img_mounted || mnt_pend) begin
                        mnt_pend <= 1'b0;
                        target   <= run_tgt;
                        if (run_tgt != vsd_sel) begin
                            state    <= PEND;
                            pend_cnt <= '0;
                        end
                    end
                end
                PEND: begin
                    if (img_mounted) begin
                        target <= new_tgt;
                    end
                    if (img_mounted && (new_tgt == vsd_sel)) begin
                        state <= RUN;
                    end else if (bus_idle || (pend_cnt == PW'(PEND_TIMEOUT - 1))) begin
                        state  <= SWITCH;
                        forced <= !bus_idle;
                    end else begin
                        pend_cnt <= pend_cnt + 1'b1;
                    end
                end
                SWITCH: begin
                    vsd_sel <= target;
                    if (img_mounted) begin
                        target   <= new_tgt;
                        mnt_pend <= 1'b1;
                    end
                    // A forced switch may have cut a transfer short, so the
                    // core is always reset in that case.
                    if (rst_after_mnt || forced) begin
                        state      <= RSTHOLD;
                        core_reset <= 1'b1;
                        rst_cnt    <= '0;
                    end else begin
                        state <= RUN;
                    end
                end
                RSTHOLD: begin
                    if (img_mounted) begin
                        target   <= new_tgt;
                        mnt_pend <= 1'b1;
                    end
                    if (rst_cnt == RW'(RST_CYCLES - 1)) begin
                        core_reset <= 1'b0;
                        state      <= RUN;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            mosi_q  <= 1'b0;
            miso_q  <= 1'b0;
            act_cnt <= '0;
        end else begin
            mosi_q <= core_mosi;
            miso_q <= core_miso;
            if ((core_mosi != mosi_q) || (core_miso != miso_q)) begin
                act_cnt <= AW'(ACT_TIMEOUT);
            end else if (act_cnt != '0) begin
                act_cnt <= act_cnt - 1'b1;
            end
        end
    end

    // During the single SWITCH cycle both targets are deselected and the
    // physical clock/data are parked low so neither card sees a partial edge.
    assign gate      = (state == SWITCH);
    assign busy      = (state != RUN);
    assign sd_act    = (act_cnt != '0);
    assign core_miso = vsd_sel ? vsd_miso : phys_miso;
    assign vsd_ss    = core_ss | ~vsd_sel | gate;
    assign phys_cs   = core_ss | vsd_sel | gate;
    assign phys_sck  = core_sck & ~vsd_sel & ~gate;
    assign phys_mosi = core_mosi & ~vsd_sel & ~gate;

endmodule

// File: tb/tb_sd_path_arbiter.sv
// tb/tb_sd_path_arbiter.sv - scoreboard bench for sd_path_arbiter
module tb_sd_path_arbiter;

    localparam int IDLE_CYCLES  = 4;
    localparam int PEND_TIMEOUT = 32;
    localparam int RST_CYCLES   = 8;
    localparam int ACT_TIMEOUT  = 16;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        img_mounted = 1'b0;
    logic [63:0] img_size = '0;
    logic        rst_after_mnt = 1'b0;
    logic        core_sck = 1'b0;
    logic        core_mosi = 1'b0;
    logic        core_ss = 1'b1;
    logic        core_miso;
    logic        vsd_ss;
    logic        vsd_miso = 1'b0;
    logic        phys_cs;
    logic        phys_sck;
    logic        phys_mosi;
    logic        phys_miso = 1'b0;
    logic        vsd_sel;
    logic        core_reset;
    logic        sd_act;
    logic        busy;

    sd_path_arbiter #(
        .IDLE_CYCLES (IDLE_CYCLES),
        .PEND_TIMEOUT(PEND_TIMEOUT),
        .RST_CYCLES  (RST_CYCLES),
        .ACT_TIMEOUT (ACT_TIMEOUT)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .img_mounted  (img_mounted),
        .img_size     (img_size),
        .rst_after_mnt(rst_after_mnt),
        .core_sck     (core_sck),
        .core_mosi    (core_mosi),
        .core_ss      (core_ss),
        .core_miso    (core_miso),
        .vsd_ss       (vsd_ss),
        .vsd_miso     (vsd_miso),
        .phys_cs      (phys_cs),
        .phys_sck     (phys_sck),
        .phys_mosi    (phys_mosi),
        .phys_miso    (phys_miso),
        .vsd_sel      (vsd_sel),
        .core_reset   (core_reset),
        .sd_act       (sd_act),
        .busy         (busy)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef enum int {EV_GATE, EV_SEL, EV_RST, EV_BUSY} ev_kind_e;
    typedef struct {
        int       cyc;
        ev_kind_e kind;
        bit       val;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;
    bit  exp_miso = 1'b0;
    bit  cur_sel = 1'b0;
    bit  prev_sel = 1'b0, prev_rst = 1'b0, prev_busy = 1'b0;
    bit  prev_mosi = 1'b0, prev_miso = 1'b0;
    int  last_toggle = -1000;

    function automatic void push_ev(int c, ev_kind_e k, bit v);
        ev_t e;
        e.cyc = c; e.kind = k; e.val = v;
        exp_q.push_back(e);
    endfunction

    function automatic logic [63:0] nz_size();
        logic [63:0] v;
        v = {$urandom(), $urandom()} | (64'd1 << $urandom_range(0, 63));
        return v;
    endfunction

    task automatic chk(input string name, input logic got, input logic req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0b, required %0b (cycle %0d)", name, got, req, cyc);
        end
    endtask

    task automatic match_ev(input ev_kind_e k, input bit v, input int c);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event: got %s=%0d @%0d, required no event", k.name(), v, c);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v || e.cyc != c) begin
                errors++;
                $display("FAIL event: got %s=%0d @%0d, required %s=%0d @%0d",
                         k.name(), v, c, e.kind.name(), e.val, e.cyc);
            end
        end
    endtask

    // Monitor: compares observed output changes against the scoreboard and
    // checks the activity LED against a sliding-window view of the toggles.
    always @(negedge clk_sys) begin
        if (reset) begin
            prev_mosi   = 1'b0;
            prev_miso   = 1'b0;
            last_toggle = -1000;
        end else begin
            if (mon_en) begin
                if (!core_ss && phys_cs && vsd_ss) begin
                    match_ev(EV_GATE, 1'b1, cyc);
                    chk("gate_parks_phys", phys_sck | phys_mosi, 1'b0);
                end
                if (vsd_sel !== prev_sel)  match_ev(EV_SEL, vsd_sel, cyc);
                if (core_reset !== prev_rst) match_ev(EV_RST, core_reset, cyc);
                if (busy !== prev_busy)    match_ev(EV_BUSY, busy, cyc);
                while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missed_event: got nothing @%0d, required %s=%0d @%0d",
                             cyc, exp_q[0].kind.name(), exp_q[0].val, exp_q[0].cyc);
                    void'(exp_q.pop_front());
                end
                chk("sd_act", sd_act, (last_toggle >= cyc - ACT_TIMEOUT));
            end
            if (core_mosi !== prev_mosi || exp_miso !== prev_miso) last_toggle = cyc;
            prev_mosi = core_mosi;
            prev_miso = exp_miso;
        end
        prev_sel  = vsd_sel;
        prev_rst  = core_reset;
        prev_busy = busy;
    end

    // Reference timing of one mount request, from the rules: PEND starts the
    // cycle after the strobe, the decision is taken in the first PEND cycle
    // that has IDLE_CYCLES quiet cycles behind it, or at the PEND_TIMEOUT-th.
    task automatic plan(input int s, input bit tgt, input bit cur, input bit ram,
                        input int last_act, input int cancel_c,
                        output int w, output bit did_rst, output bit switched,
                        output bit cancel_used, output int last_ev);
        int p_idle, p_to, decide;
        bit forced;
        w = 0; did_rst = 0; switched = 0; cancel_used = 0; last_ev = s;
        if (tgt == cur) return;
        p_idle = (last_act + IDLE_CYCLES + 1 > s + 1) ? last_act + IDLE_CYCLES + 1 : s + 1;
        p_to   = s + PEND_TIMEOUT;
        forced = (p_idle > p_to);
        decide = forced ? p_to : p_idle;
        push_ev(s + 1, EV_BUSY, 1'b1);
        if (cancel_c >= s + 1 && cancel_c <= decide) begin
            cancel_used = 1;
            push_ev(cancel_c + 1, EV_BUSY, 1'b0);
            last_ev = cancel_c + 1;
            return;
        end
        w = decide + 1;
        switched = 1;
        if (w <= last_act) push_ev(w, EV_GATE, 1'b1);
        push_ev(w + 1, EV_SEL, tgt);
        if (ram || forced) begin
            did_rst = 1;
            push_ev(w + 1, EV_RST, 1'b1);
            push_ev(w + 1 + RST_CYCLES, EV_RST, 1'b0);
            push_ev(w + 1 + RST_CYCLES, EV_BUSY, 1'b0);
            last_ev = w + 1 + RST_CYCLES;
        end else begin
            push_ev(w + 1, EV_BUSY, 1'b0);
            last_ev = w + 1;
        end
    endtask

    task automatic episode(input bit tgt, input bit ram, input int strobe_off, input int act_len,
                           input bit do_cancel, input int cancel_off, input bit do_rsth);
        int base, s, last_act, cancel_c, rsth_c, w, w2, last_ev, le2, end_c;
        bit did_rst, sw, cu, tgt2, r2, sw2, cu2, old_sel, m;
        @(posedge clk_sys); #1;
        base     = cyc;
        s        = base + strobe_off;
        last_act = base + act_len - 1;
        old_sel  = cur_sel;
        cancel_c = do_cancel ? s + cancel_off : -1;
        plan(s, tgt, cur_sel, ram, last_act, cancel_c, w, did_rst, sw, cu, last_ev);
        if (!cu) cancel_c = -1;
        if (sw) cur_sel = tgt;
        rsth_c = -1;
        tgt2 = 1'b0;
        if (did_rst && do_rsth) begin
            rsth_c = w + 1 + $urandom_range(0, RST_CYCLES - 1);
            tgt2   = 1'($urandom());
            plan(w + 1 + RST_CYCLES, tgt2, cur_sel, ram, last_act, -1, w2, r2, sw2, cu2, le2);
            if (sw2) begin
                cur_sel = tgt2;
                last_ev = le2;
            end
        end
        end_c = (last_ev > last_act ? last_ev : last_act) + 8;
        rst_after_mnt = ram;
        for (int c = base; c <= end_c; c++) begin
            if (c != base) begin
                @(posedge clk_sys); #1;
            end
            if (c <= last_act) begin
                core_ss   = 1'b0;
                core_sck  = 1'($urandom());
                core_mosi = 1'($urandom());
            end else begin
                core_ss = 1'b1;
            end
            m = 1'($urandom());
            vsd_miso  = m;
            phys_miso = m;
            exp_miso  = m;
            img_mounted = 1'b0;
            if (c == s) begin
                img_mounted = 1'b1;
                img_size    = tgt ? nz_size() : 64'd0;
            end else if (c == cancel_c) begin
                img_mounted = 1'b1;
                img_size    = old_sel ? nz_size() : 64'd0;
            end else if (c == rsth_c) begin
                img_mounted = 1'b1;
                img_size    = tgt2 ? nz_size() : 64'd0;
            end
        end
    endtask

    task automatic mux_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys); #1;
            img_mounted = 1'b0;
            core_ss   = 1'($urandom());
            core_sck  = 1'($urandom());
            core_mosi = 1'($urandom());
            vsd_miso  = 1'($urandom());
            phys_miso = 1'($urandom());
            exp_miso  = cur_sel ? vsd_miso : phys_miso;
            #1;
            chk("core_miso", core_miso, exp_miso);
            chk("vsd_ss", vsd_ss, core_ss | ~cur_sel);
            chk("phys_cs", phys_cs, core_ss | cur_sel);
            chk("phys_sck", phys_sck, core_sck & ~cur_sel);
            chk("phys_mosi", phys_mosi, core_mosi & ~cur_sel);
        end
    endtask

    task automatic act_test();
        @(posedge clk_sys); #1;
        core_ss = 1'b1; img_mounted = 1'b0;
        vsd_miso = exp_miso; phys_miso = exp_miso;
        core_mosi = ~core_mosi;
        repeat (5) @(posedge clk_sys);
        #1 core_mosi = ~core_mosi;
        repeat (ACT_TIMEOUT + 8) @(posedge clk_sys);
        #1;
    endtask

    task automatic reset_in_rsthold();
        int s;
        episode(1'b0, 1'b0, 6, 1, 1'b0, 0, 1'b0);
        mon_en = 1'b0;
        exp_q.delete();
        @(posedge clk_sys); #1;
        s = cyc;
        rst_after_mnt = 1'b1;
        img_size    = nz_size();
        img_mounted = 1'b1;
        @(posedge clk_sys); #1;
        img_mounted = 1'b0;
        core_mosi   = ~core_mosi;
        repeat (4) @(posedge clk_sys);
        #2;
        chk("rsthold3_cycle", (cyc == s + 5), 1'b1);
        chk("rsthold3_core_reset", core_reset, 1'b1);
        chk("rsthold3_busy", busy, 1'b1);
        chk("rsthold3_vsd_sel", vsd_sel, 1'b1);
        chk("rsthold3_sd_act", sd_act, 1'b1);
        reset = 1'b1;
        #1;
        chk("async_core_reset", core_reset, 1'b0);
        chk("async_busy", busy, 1'b0);
        chk("async_vsd_sel", vsd_sel, 1'b0);
        chk("async_sd_act", sd_act, 1'b0);
        @(posedge clk_sys); #1;
        reset = 1'b0;
        repeat (4) @(posedge clk_sys);
        #1;
        chk("after_reset_busy", busy, 1'b0);
        chk("after_reset_core_reset", core_reset, 1'b0);
        chk("after_reset_vsd_sel", vsd_sel, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, required finish before 1000000");
        $fatal(1, "watchdog");
    end

    initial begin
        int so, al, mode;
        repeat (3) @(posedge clk_sys);
        #1;
        chk("reset_vsd_sel", vsd_sel, 1'b0);
        chk("reset_core_reset", core_reset, 1'b0);
        chk("reset_sd_act", sd_act, 1'b0);
        chk("reset_busy", busy, 1'b0);
        reset  = 1'b0;
        mon_en = 1'b1;

        episode(1'b1, 1'b0, 8, 1, 1'b0, 0, 1'b0);
        episode(1'b0, 1'b0, 2, 50, 1'b0, 0, 1'b0);
        episode(1'b1, 1'b0, 2, 30, 1'b1, 5, 1'b0);
        episode(1'b1, 1'b0, 3, 1, 1'b0, 0, 1'b0);
        mux_check(12);
        episode(1'b0, 1'b1, 3, 1, 1'b0, 0, 1'b0);
        mux_check(12);
        act_test();

        for (int i = 0; i < 40; i++) begin
            so   = $urandom_range(1, 8);
            mode = $urandom_range(0, 2);
            if (mode == 0)      al = $urandom_range(1, so);
            else if (mode == 1) al = so + $urandom_range(1, 20);
            else                al = so + $urandom_range(28, 45);
            episode(1'($urandom()), 1'($urandom()), so, al,
                    ($urandom_range(0, 3) == 0), $urandom_range(1, 12), 1'($urandom()));
            if (i % 8 == 7) mux_check(6);
        end

        chk("scoreboard_drained", (exp_q.size() == 0), 1'b1);
        reset_in_rsthold();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
